serial_pulse_tx: RTL and testbench
==================================

# serial_pulse_tx

Pulse-width serial transmitter that sits directly upstream of the pulse-width LED receiver and drives its `rxd` line. It accepts one 8-bit frame per dav_/rfd handshake: a 5-bit destination address in the high bits and a 3-bit LED pattern in the low bits. It sends the frame LSB first, one low pulse per bit: a short pulse encodes 1, a long pulse encodes 0. Each pulse is followed by a fixed high gap.

## Interface
- SHORT_LEN, 4: txd low cycles for a 1; legal range 2..6, so the receiver's count stays below 8.
- LONG_LEN, 12: txd low cycles for a 0; legal range 10..15, so the receiver's count is at least 8 and its 4-bit counter does not wrap.
- GAP_LEN, 4: txd high cycles after every pulse; minimum 3, so the receiver can return to its wait state.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- addr  in  5  destination address; becomes frame bits [7:3].
- data  in  3  LED pattern; becomes frame bits [2:0].
- dav_  in  1  data valid, active low; addr and data must be stable while it is low.
- rfd  out  1  ready for data; 1 only in IDLE.
- txd  out  1  serial line; idle level 1.

## Operation
- Registers: BUF[7:0] (latched frame), NBIT[2:0] (bit index), CNT[3:0] (cycle down-counter), TXD, RFD, STAR.
- Reset values: STAR=IDLE, TXD=1, RFD=1, BUF=0, NBIT=0, CNT=0.
- Current bit is BUF[NBIT]. BUF is never shifted.
- Pulse length: len(b) = b ? SHORT_LEN : LONG_LEN.
- IDLE
  - If dav_=0: BUF<={addr,data}, NBIT<=0, RFD<=0, TXD<=0, CNT<=len(data[0])-1, go to LOW.
  - Otherwise hold.
- LOW
  - If CNT==0: TXD<=1, CNT<=GAP_LEN-1, go to HIGH.
  - Otherwise CNT<=CNT-1.
- HIGH
  - If CNT!=0: CNT<=CNT-1.
  - Else if NBIT!=7: NBIT<=NBIT+1, TXD<=0, CNT<=len(BUF[NBIT+1])-1, go to LOW.
  - Else: go to WAIT.
- WAIT
  - TXD=1, RFD=0.
  - If dav_=1: RFD<=1, go to IDLE. This completes the four-phase handshake.
- dav_ is ignored outside IDLE and WAIT. addr and data changes after the sampling edge have no effect.
- Reset mid-frame: TXD immediately returns to 1 and RFD to 1. The partial frame is abandoned. The downstream receiver's recovery is its own concern.

## Timing
- Sampling edge: the rising edge in IDLE with dav_=0. txd falls and rfd falls on that same edge.
- Each bit: txd is low for exactly len(b) cycles, then high for exactly GAP_LEN cycles.
- Frame length: sum over the 8 bits of (len(b)+GAP_LEN) cycles. With defaults, all-ones is 64 cycles and all-zeros is 128.
- End of frame: the first edge after the last gap enters WAIT. If dav_ is already 1, rfd rises one edge later; otherwise it rises on the first edge that sees dav_=1.
- Back to back: minimum spacing between two sampling edges is the frame length + 2 cycles.

## Configuration
- SERIAL_PULSE_TX_REPEAT_EN
  - Defined: each frame is transmitted twice for redundancy. A 1-bit REP flag is added. After the last gap of the first copy, NBIT<=0 and transmission restarts from BUF[0]; WAIT is entered only after the second copy. The receiver applies the same LED value twice, which is idempotent.
  - Undefined: single transmission; REP does not exist.

## Structure
- Shared package serial_pulse_pkg:
  - state encodings IDLE/LOW/HIGH/WAIT
  - FRAME_BITS=8, ADDR_W=5, DATA_W=3
  - default SHORT_LEN, LONG_LEN and GAP_LEN values, so the receiver-side threshold (8) and the transmitter-side lengths live in one place
- One natural sub-module: pulse_timer, a loadable 4-bit down-counter with a zero flag that drives CNT.

## Test plan
- Reset with dav_=1 -> txd=1, rfd=1, no activity for 50 cycles.
- addr=5'b10110, data=3'b101 (frame 8'hB5) -> low pulses of 4,12,4,12,4,4,12,4 cycles, each followed by 4 high cycles; 88 cycles total; rfd=0 throughout.
- Same frame through the downstream receiver with ref=5'b10110 -> led=3'b101 after the frame; rerun with ref=5'b00000 -> led unchanged.
- Hold dav_=0 for 200 cycles -> exactly one frame sent; rfd stays 0 until dav_ rises, then rfd=1 one edge later.
- Assert reset_ at cycle 30 of a frame -> txd=1 and rfd=1 asynchronously; the next frame starts cleanly from bit 0.
- With SERIAL_PULSE_TX_REPEAT_EN, frame 8'hFF -> 16 pulses of 4 low / 4 high (128 cycles), then WAIT.

Source files
------------

// File: rtl/serial_pulse_pkg.sv
// Shared constants for the pulse-width serial link (transmitter and receiver).
// Build macro SERIAL_PULSE_TX_REPEAT_EN enables twice-sent frames in the transmitter.
package serial_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT
  } tx_state_t;

  localparam int FRAME_BITS = 8;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 3;
  localparam int CNT_W      = 4;

  // Receiver decides 1 vs 0 by comparing its low count to this threshold.
  localparam int RX_THRESHOLD  = 8;
  localparam int SHORT_LEN_DEF = 4;
  localparam int LONG_LEN_DEF  = 12;
  localparam int GAP_LEN_DEF   = 4;

  function automatic logic [CNT_W-1:0] len_m1(
    input logic b,
    input int   short_len,
    input int   long_len
  );
    return b ? CNT_W'(short_len - 1) : CNT_W'(long_len - 1);
  endfunction

endpackage

// File: rtl/serial_pulse_tx_pulse_timer.sv
// Loadable down-counter that times each low pulse and high gap.
// Load has priority over decrement; zero flag is combinational on the count.
module pulse_timer
  import serial_pulse_pkg::*;
(
  input  logic             clock,
  input  logic             reset_,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_pulse_tx.sv
// Pulse-width serial transmitter: one frame per dav_/rfd handshake, LSB first.
// SERIAL_PULSE_TX_REPEAT_EN: send every frame twice before entering WAIT.
module serial_pulse_tx
  import serial_pulse_pkg::*;
#(
  parameter int SHORT_LEN = SHORT_LEN_DEF,
  parameter int LONG_LEN  = LONG_LEN_DEF,
  parameter int GAP_LEN   = GAP_LEN_DEF
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              dav_,
  output logic              rfd,
  output logic              txd
);

  tx_state_t             state;
  logic [FRAME_BITS-1:0] frame_q;
  logic [2:0]            nbit;
  logic [2:0]            nbit_nx;
  logic                  last_copy;

  logic             tmr_load;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

`ifdef SERIAL_PULSE_TX_REPEAT_EN
  logic rep;
  assign last_copy = rep;
`else
  assign last_copy = 1'b1;
`endif

  // Wraps 7 -> 0, which is exactly the restart bit for the repeat copy.
  assign nbit_nx = nbit + 3'd1;

  pulse_timer u_timer (
    .clock    (clock),
    .reset_   (reset_),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    unique case (state)
      IDLE: begin
        if (!dav_) begin
          tmr_load = 1'b1;
          tmr_val  = len_m1(data[0], SHORT_LEN, LONG_LEN);
        end
      end
      LOW: begin
        if (cnt_zero) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_LEN - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HIGH: begin
        if (!cnt_zero) begin
          tmr_dec = 1'b1;
        end else if (nbit != 3'd7 || !last_copy) begin
          tmr_load = 1'b1;
          tmr_val  = len_m1(frame_q[nbit_nx], SHORT_LEN, LONG_LEN);
        end
      end
      WAIT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      txd     <= 1'b1;
      rfd     <= 1'b1;
      frame_q <= '0;
      nbit    <= '0;
`ifdef SERIAL_PULSE_TX_REPEAT_EN
      rep     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!dav_) begin
            frame_q <= {addr, data};
            nbit    <= '0;
            rfd     <= 1'b0;
            txd     <= 1'b0;
            state   <= LOW;
`ifdef SERIAL_PULSE_TX_REPEAT_EN
            rep     <= 1'b0;
`endif
          end
        end
        LOW: begin
          if (cnt_zero) begin
            txd   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            if (nbit != 3'd7 || !last_copy) begin
              nbit  <= nbit_nx;
              txd   <= 1'b0;
              state <= LOW;
`ifdef SERIAL_PULSE_TX_REPEAT_EN
              if (nbit == 3'd7) rep <= 1'b1;
`endif
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          txd <= 1'b1;
          rfd <= 1'b0;
          if (dav_) begin
            rfd   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pulse_tx.sv
// Scoreboard bench for serial_pulse_tx: driver queues expected pulses,
// a line monitor measures txd low/high runs and decodes frames like the receiver.
module tb_serial_pulse_tx;
  import serial_pulse_pkg::*;

  localparam int SL = SHORT_LEN_DEF;
  localparam int LL = LONG_LEN_DEF;
  localparam int GL = GAP_LEN_DEF;
`ifdef SERIAL_PULSE_TX_REPEAT_EN
  localparam int COPIES = 2;
`else
  localparam int COPIES = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic [4:0] addr = '0;
  logic [2:0] data = '0;
  logic       dav_ = 1'b1;
  logic       rfd;
  logic       txd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int len;
    bit last;
  } pulse_t;

  pulse_t exp_q[$];

  logic [4:0] rx_ref = 5'b11111;
  logic [2:0] led = 3'b000;

  serial_pulse_tx dut (
    .clock  (clock),
    .reset_ (reset_),
    .addr   (addr),
    .data   (data),
    .dav_   (dav_),
    .rfd    (rfd),
    .txd    (txd)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int frame_len(logic [7:0] f);
    int s = 0;
    for (int i = 0; i < 8; i++) s += (f[i] ? SL : LL) + GL;
    return s * COPIES;
  endfunction

  task automatic push_frame(logic [7:0] f);
    for (int c = 0; c < COPIES; c++)
      for (int i = 0; i < 8; i++)
        exp_q.push_back('{len: (f[i] ? SL : LL),
                          last: (c == COPIES - 1 && i == 7)});
  endtask

  // Line monitor: behaves like the downstream receiver plus timing checks.
  int       low_cnt = 0;
  int       high_cnt = 0;
  bit       prev = 1'b1;
  bit       seen_pulse = 1'b0;
  bit       after_last = 1'b0;
  int       rx_bits = 0;
  logic [7:0] rx_byte = '0;

  always @(negedge clock) begin
    pulse_t p;
    if (!reset_) begin
      low_cnt    = 0;
      high_cnt   = 0;
      prev       = 1'b1;
      seen_pulse = 1'b0;
      after_last = 1'b0;
      rx_bits    = 0;
    end else if (txd === 1'b0) begin
      if (prev) begin
        if (seen_pulse) begin
          if (after_last)
            chk("frame_spacing", 32'(high_cnt >= GL + 2), 32'd1);
          else
            chk("gap_len", high_cnt, GL);
        end
        low_cnt = 0;
      end
      low_cnt++;
      prev = 1'b0;
    end else begin
      if (!prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", low_cnt, 0);
        end else begin
          p = exp_q.pop_front();
          chk("pulse_len", low_cnt, p.len);
          after_last = p.last;
        end
        rx_byte[rx_bits[2:0]] = (low_cnt < RX_THRESHOLD);
        rx_bits++;
        if (rx_bits == 8) begin
          rx_bits = 0;
          if (rx_byte[7:3] == rx_ref) led = rx_byte[2:0];
        end
        seen_pulse = 1'b1;
        high_cnt = 0;
      end
      high_cnt++;
      prev = 1'b1;
    end
  end

  task automatic send(logic [4:0] a, logic [2:0] d, int hold);
    logic [7:0] f;
    int         flen;
    f    = {a, d};
    flen = frame_len(f);
    chk("rfd_idle", rfd, 1);
    addr = a;
    data = d;
    push_frame(f);
    dav_ = 1'b0;
    @(negedge clock);
    chk("rfd_fall", rfd, 0);
    addr = 5'($urandom);
    data = 3'($urandom);
    if (hold == 0) dav_ = 1'b1;
    repeat (flen) begin
      @(negedge clock);
      chk("rfd_busy", rfd, 0);
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clock);
        chk("rfd_held", rfd, 0);
      end
      dav_ = 1'b1;
    end
    @(negedge clock);
    chk("rfd_rise", rfd, 1);
    chk("pulses_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    repeat (50) begin
      @(negedge clock);
      chk("reset_txd", txd, 1);
      chk("reset_rfd", rfd, 1);
    end

    rx_ref = 5'b10110;
    send(5'b10110, 3'b101, 0);
    chk("led_match", led, 3'b101);
    rx_ref = 5'b00000;
    send(5'b10110, 3'b010, 0);
    chk("led_unchanged", led, 3'b101);

    send(5'b01010, 3'b011, 200 - frame_len(8'h53));
    send(5'b11111, 3'b111, 0);
    send(5'b00000, 3'b000, 0);

    // Reset in the middle of a frame.
    addr = 5'b10110;
    data = 3'b101;
    push_frame(8'hB5);
    dav_ = 1'b0;
    @(negedge clock);
    dav_ = 1'b1;
    repeat (29) @(negedge clock);
    #2 reset_ = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_rfd", rfd, 1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    #1 reset_ = 1'b1;
    @(negedge clock);
    rx_ref = 5'b00110;
    send(5'b00110, 3'b001, 0);
    chk("led_after_reset", led, 3'b001);

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send(5'($urandom), 3'($urandom),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
